// File: rtl/datapath.sv
// -----------------------------------------------------------------------------
// datapath: register file plus ALU execution datapath for the DJ core.
//
// Two combinational read ports select the ALU operands from a 2**ADDR_W entry
// register file. One synchronous write port loads the file from an external
// bus. Zero, negative and overflow status of the ALU result are registered
// and exported to the control unit.
//
// Optional feature macro: DATAPATH_RESULT_PORT_EN
//   defined   -> adds output alu_result, the unregistered ALU result
//   undefined -> the result stays internal; flag behaviour is identical
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   reg_read_addr_1  in   operand A register select
//   reg_read_addr_2  in   operand B register select
//   reg_write_addr   in   write register select
//   reg_write_data   in   write data
//   reg_write_cmd    in   write enable
//   alu_operation    in   ALU opcode
//   alu_result       out  combinational ALU result (feature builds only)
//   zero_flag        out  registered: result == 0
//   negative_flag    out  registered: result MSB
//   overflow_flag    out  registered: signed overflow of ADD/SUB
// -----------------------------------------------------------------------------
module datapath #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    input  logic [ADDR_W-1:0] reg_write_addr,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic              reg_write_cmd,
    input  logic [7:0]        alu_operation,
`ifdef DATAPATH_RESULT_PORT_EN
    output logic [DATA_W-1:0] alu_result,
`endif
    output logic              zero_flag,
    output logic              negative_flag,
    output logic              overflow_flag
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned SHAMT_W  = 6;

    localparam logic [7:0] OP_PASS = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_NOT  = 8'h06;
    localparam logic [7:0] OP_SLL  = 8'h07;
    localparam logic [7:0] OP_SRL  = 8'h08;
    localparam logic [7:0] OP_SRA  = 8'h09;
    localparam logic [7:0] OP_SLT  = 8'h0A;
    localparam logic [7:0] OP_SLTU = 8'h0B;

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] reg_file [NUM_REGS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                reg_file[i] <= '0;
            end
        end else if (reg_write_cmd) begin
            reg_file[reg_write_addr] <= reg_write_data;
        end
    end

    // No write-through: a read of the address being written sees the old
    // contents until the edge, so flags on a write edge use pre-write data.
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;

    assign operand_a = reg_file[reg_read_addr_1];
    assign operand_b = reg_file[reg_read_addr_2];

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0]  sum;
    logic [DATA_W-1:0]  diff;
    logic [SHAMT_W-1:0] shamt;
    logic               sign_a;
    logic               sign_b;
    logic               add_ovf;
    logic               sub_ovf;
    logic [DATA_W-1:0]  result;
    logic               result_ovf;

    assign sum    = operand_a + operand_b;
    assign diff   = operand_a - operand_b;
    assign shamt  = operand_b[SHAMT_W-1:0];
    assign sign_a = operand_a[DATA_W-1];
    assign sign_b = operand_b[DATA_W-1];

    // Same-sign operands that produce an opposite-sign sum overflowed.
    assign add_ovf = (sign_a == sign_b) && (sum[DATA_W-1] != sign_a);
    // Opposite-sign operands whose difference flips away from A overflowed.
    assign sub_ovf = (sign_a != sign_b) && (diff[DATA_W-1] != sign_a);

    always_comb begin
        result     = '0;
        result_ovf = 1'b0;
        case (alu_operation)
            OP_PASS: result = operand_a;
            OP_ADD: begin
                result     = sum;
                result_ovf = add_ovf;
            end
            OP_SUB: begin
                result     = diff;
                result_ovf = sub_ovf;
            end
            OP_AND:  result = operand_a & operand_b;
            OP_OR:   result = operand_a | operand_b;
            OP_XOR:  result = operand_a ^ operand_b;
            OP_NOT:  result = ~operand_a;
            OP_SLL:  result = operand_a << shamt;
            OP_SRL:  result = operand_a >> shamt;
            OP_SRA:  result = $signed(operand_a) >>> shamt;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: result = {{(DATA_W-1){1'b0}}, (operand_a < operand_b)};
            default: result = '0;
        endcase
    end

`ifdef DATAPATH_RESULT_PORT_EN
    assign alu_result = result;
`endif

    // -------------------------------------------------------------------------
    // Status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            zero_flag     <= (result == '0);
            negative_flag <= result[DATA_W-1];
            overflow_flag <= result_ovf;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// -----------------------------------------------------------------------------
// tb_datapath: self-checking bench for datapath. Each driven cycle pushes the
// expected flags (from a bench-side register model and ALU model) onto a
// scoreboard queue; after the edge the entry is popped and compared.
// -----------------------------------------------------------------------------
module tb_datapath;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 8;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] reg_read_addr_1;
    logic [ADDR_W-1:0] reg_read_addr_2;
    logic [ADDR_W-1:0] reg_write_addr;
    logic [DATA_W-1:0] reg_write_data;
    logic              reg_write_cmd;
    logic [7:0]        alu_operation;
    logic              zero_flag;
    logic              negative_flag;
    logic              overflow_flag;
`ifdef DATAPATH_RESULT_PORT_EN
    logic [DATA_W-1:0] alu_result;
`endif

    datapath #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .reg_read_addr_1 (reg_read_addr_1),
        .reg_read_addr_2 (reg_read_addr_2),
        .reg_write_addr  (reg_write_addr),
        .reg_write_data  (reg_write_data),
        .reg_write_cmd   (reg_write_cmd),
        .alu_operation   (alu_operation),
`ifdef DATAPATH_RESULT_PORT_EN
        .alu_result      (alu_result),
`endif
        .zero_flag       (zero_flag),
        .negative_flag   (negative_flag),
        .overflow_flag   (overflow_flag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string       tag;
        logic [2:0]  flags;   // {zero, negative, overflow}
        logic [63:0] result;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    logic [63:0] model_regs [256];
    int          n_checks;
    int          n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, result}; overflow derived from a 65-bit signed sum.
    function automatic logic [64:0] alu_model(input logic [7:0] op, input logic [63:0] a,
                                              input logic [63:0] b);
        logic signed [64:0] wide;
        logic [63:0]        r;
        logic               v;
        r = '0;
        v = 1'b0;
        case (op)
            8'h00: r = a;
            8'h01: begin
                wide = $signed({a[63], a}) + $signed({b[63], b});
                r    = wide[63:0];
                v    = wide[64] != wide[63];
            end
            8'h02: begin
                wide = $signed({a[63], a}) - $signed({b[63], b});
                r    = wide[63:0];
                v    = wide[64] != wide[63];
            end
            8'h03: r = a & b;
            8'h04: r = a | b;
            8'h05: r = a ^ b;
            8'h06: r = ~a;
            8'h07: r = a << b[5:0];
            8'h08: r = a >> b[5:0];
            8'h09: r = $signed(a) >>> b[5:0];
            8'h0A: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            8'h0B: r = (a < b) ? 64'd1 : 64'd0;
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    task automatic pop_and_check();
        sb_entry_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, {61'd0, zero_flag, negative_flag, overflow_flag}, {61'd0, e.flags});
`ifdef DATAPATH_RESULT_PORT_EN
            check({e.tag, ".prev_result"}, 64'd0, 64'd0 & e.result);
`endif
        end
    endtask

    // Drive one cycle, predict flags from pre-write model state, then check.
    task automatic step(input string tag, input logic [7:0] op, input logic [7:0] ra1,
                        input logic [7:0] ra2, input logic we, input logic [7:0] wa,
                        input logic [63:0] wd);
        logic [64:0] m;
        sb_entry_t   e;
        @(negedge clock);
        alu_operation   = op;
        reg_read_addr_1 = ra1;
        reg_read_addr_2 = ra2;
        reg_write_cmd   = we;
        reg_write_addr  = wa;
        reg_write_data  = wd;
        m = alu_model(op, model_regs[ra1], model_regs[ra2]);
        e.tag    = tag;
        e.flags  = {(m[63:0] == 64'd0), m[63], m[64]};
        e.result = m[63:0];
        sb_q.push_back(e);
`ifdef DATAPATH_RESULT_PORT_EN
        #1 check({tag, ".result"}, alu_result, m[63:0]);
`endif
        if (we) model_regs[wa] = wd;
        @(posedge clock);
        #1 pop_and_check();
    endtask

    task automatic wr(input logic [7:0] wa, input logic [63:0] wd);
        step("write", 8'h00, 8'd0, 8'd0, 1'b1, wa, wd);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 256; i++) model_regs[i] = '0;
        reset           = 1'b0;
        reg_read_addr_1 = '0;
        reg_read_addr_2 = '0;
        reg_write_addr  = '0;
        reg_write_data  = '0;
        reg_write_cmd   = 1'b0;
        alu_operation   = 8'h06;   // NOT A of 0 would set N if reset were ignored
        repeat (2) @(posedge clock);
        #1 check("reset_flags", {61'd0, zero_flag, negative_flag, overflow_flag}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Reset clears registers and flags asynchronously.
        wr(8'd2, 64'hAAAA_AAAA_AAAA_AAAA);
        step("pass_reg2_pre_reset", 8'h00, 8'd2, 8'd0, 1'b0, 8'd0, 64'd0);
        #2 reset = 1'b0;
        #1 check("async_reset_flags", {61'd0, zero_flag, negative_flag, overflow_flag}, 64'd0);
        @(negedge clock);
        alu_operation = 8'h06;
        @(posedge clock);
        #1 check("held_reset_flags", {61'd0, zero_flag, negative_flag, overflow_flag}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) model_regs[i] = '0;
        step("reg2_cleared", 8'h00, 8'd2, 8'd0, 1'b0, 8'd0, 64'd0);

        // Directed operations.
        wr(8'd2, 64'hAAAA_AAAA_AAAA_AAAA);
        wr(8'd3, 64'hBBBB_BBBB_BBBB_BBBB);
        wr(8'd6, 64'h8000_0000_0000_0000);
        wr(8'd7, 64'd1);
        wr(8'd8, 64'h7FFF_FFFF_FFFF_FFFF);
        step("pass_reg2", 8'h00, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("pass_reg3", 8'h00, 8'd3, 8'd2, 1'b0, 8'd0, 64'd0);
        step("add", 8'h01, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("sub", 8'h02, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("add_pos_ovf", 8'h01, 8'd8, 8'd7, 1'b0, 8'd0, 64'd0);
        step("sub_neg_ovf", 8'h02, 8'd6, 8'd7, 1'b0, 8'd0, 64'd0);
        step("and", 8'h03, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("or", 8'h04, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("xor_self", 8'h05, 8'd2, 8'd2, 1'b0, 8'd0, 64'd0);
        step("not", 8'h06, 8'd2, 8'd0, 1'b0, 8'd0, 64'd0);
        step("sll", 8'h07, 8'd7, 8'd3, 1'b0, 8'd0, 64'd0);
        step("srl", 8'h08, 8'd6, 8'd3, 1'b0, 8'd0, 64'd0);
        step("sra", 8'h09, 8'd6, 8'd3, 1'b0, 8'd0, 64'd0);
        step("slt_true", 8'h0A, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);
        step("slt_false", 8'h0A, 8'd7, 8'd6, 1'b0, 8'd0, 64'd0);
        step("sltu_true", 8'h0B, 8'd7, 8'd6, 1'b0, 8'd0, 64'd0);
        step("sltu_false", 8'h0B, 8'd6, 8'd7, 1'b0, 8'd0, 64'd0);
        step("undef_op", 8'hFF, 8'd2, 8'd3, 1'b0, 8'd0, 64'd0);

        // Same-edge write/read of reg4, then a disabled write.
        step("wr4_old", 8'h00, 8'd4, 8'd0, 1'b1, 8'd4, 64'h8000_0000_0000_0001);
        step("wr4_new", 8'h00, 8'd4, 8'd0, 1'b0, 8'd0, 64'd0);
        step("wr4_cmd0", 8'h00, 8'd4, 8'd0, 1'b0, 8'd4, 64'd0);
        step("wr4_hold", 8'h00, 8'd4, 8'd0, 1'b0, 8'd0, 64'd0);

        // Random traffic over a small address window.
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  op;
            logic [63:0] wd;
            op = 8'($urandom_range(0, 13));
            if (op > 8'h0B) op = 8'hC0 | op;
            case ($urandom_range(0, 3))
                0:       wd = 64'h8000_0000_0000_0000 ^ 64'($urandom_range(0, 1));
                1:       wd = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1));
                default: wd = {$urandom, $urandom};
            endcase
            step("random", op, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
Register-file plus ALU execution datapath for the DJ core. Two combinational read ports feed a 64-bit ALU. One synchronous write port loads the register file from an external bus. Zero, negative and overflow status flags of the ALU result are registered and exported to the control unit.

Parameters:
DATA_W, 64, register and ALU data width
ADDR_W, 8, register address width; the file holds 2**ADDR_W registers

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
reg_read_addr_1  input  ADDR_W  ALU operand A register select
reg_read_addr_2  input  ADDR_W  ALU operand B register select
reg_write_addr  input  ADDR_W  write register select
reg_write_data  input  DATA_W  write data
reg_write_cmd  input  1  write enable
alu_operation  input  8  ALU opcode
zero_flag  output  1  registered: result == 0
negative_flag  output  1  registered: result MSB
overflow_flag  output  1  registered: signed overflow of ADD/SUB

Behaviour:
- Reset low (asynchronous): all 2**ADDR_W registers clear to 0; all three flags clear to 0. Reset dominates any write.
- Write: on a rising clock edge with reg_write_cmd=1 and reset high, reg[reg_write_addr] <= reg_write_data. All registers, including 0, are writable.
- Reads are combinational: A = reg[reg_read_addr_1], B = reg[reg_read_addr_2]. No write-through; a read of the address being written returns the old value until the edge.
- The ALU is combinational and operates on A and B. Opcodes:
  - 0x00 PASS A
  - 0x01 ADD A+B
  - 0x02 SUB A-B
  - 0x03 AND
  - 0x04 OR
  - 0x05 XOR
  - 0x06 NOT A
  - 0x07 SLL A by B[5:0]
  - 0x08 SRL A by B[5:0]
  - 0x09 SRA A by B[5:0]
  - 0x0A SLT signed (result 1/0)
  - 0x0B SLTU unsigned (result 1/0)
  - any other opcode: result 0
- Results are truncated to DATA_W; carry-out is discarded.
- Overflow:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
  - All other opcodes: 0.
- Flags are sampled from the current ALU result on every rising edge while reset is high; one-cycle latency from an operand or opcode change.
- Flags are computed from the pre-write operand values when a write and a flag update occur on the same edge.

Optional Feature:
DATAPATH_RESULT_PORT_EN
- Defined: adds output alu_result [DATA_W-1:0], the combinational ALU result (unregistered).
- Undefined: no such port; the result is internal only. Flag behaviour is identical in both builds.

Test Plan:
- Reset: write reg 2, then pulse reset low -> reg 2 reads 0; all flags 0 while reset is low and after release.
- Write/read: write reg2=0xAAAAAAAAAAAAAAAA and reg3=0xBBBBBBBBBBBBBBBB (one cycle each) -> read ports 1/2 addressed 2/3 return those values combinationally.
- ADD: op=0x01 with A=reg2, B=reg3 -> result 0x6666666666666665; after the next edge Z=0, N=0, V=1.
- SUB: op=0x02 with A=reg2, B=reg3 -> result 0xEEEEEEEEEEEEEEEF; after the next edge Z=0, N=1, V=0.
- Zero/logic: XOR with A=reg2, B=reg2 -> result 0, Z=1; undefined opcode 0xFF -> Z=1, N=0, V=0.
- Same-edge write and read: write reg4 while reading reg4 -> old value before the edge, new value after; reg_write_cmd=0 -> no register changes.
